// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: rotor/reflector wirings, notches, FSM states and
// modular arithmetic helpers for the 26-letter alphabet.
package enigma_pkg;

    localparam int SYM_BITS  = 5;
    localparam int ALPHA_LEN = 26;

    localparam logic [SYM_BITS-1:0] ALPHA_MAX   = SYM_BITS'(ALPHA_LEN - 1);
    localparam logic [SYM_BITS:0]   ALPHA_LEN_W = (SYM_BITS+1)'(ALPHA_LEN);

    // Wirings stored as letter strings; entry 0 is the leftmost character.
    localparam logic [8*ALPHA_LEN-1:0] WIRE_I       = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [8*ALPHA_LEN-1:0] WIRE_I_INV   = "UWYGADFPVZBECKMTHXSLRINQOJ";
    localparam logic [8*ALPHA_LEN-1:0] WIRE_II      = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [8*ALPHA_LEN-1:0] WIRE_II_INV  = "AJPCZWRLFBDKOTYUQGENHXMIVS";
    localparam logic [8*ALPHA_LEN-1:0] WIRE_III     = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [8*ALPHA_LEN-1:0] WIRE_III_INV = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
    localparam logic [8*ALPHA_LEN-1:0] REFL_B       = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_REFL,
        ST_REV,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        DIR_FWD,
        DIR_REV,
        DIR_REFL
    } stage_dir_t;

    // Look up entry idx (0..25) of a wiring string, returned as 0..25.
    function automatic logic [SYM_BITS-1:0] tbl(input logic [8*ALPHA_LEN-1:0] t,
                                                input logic [SYM_BITS-1:0] idx);
        logic [7:0] ch;
        ch = t[8*(ALPHA_LEN - 1 - int'(idx)) +: 8];
        return SYM_BITS'(ch - 8'd65);
    endfunction

    function automatic logic [SYM_BITS-1:0] mod_add(input logic [SYM_BITS-1:0] a,
                                                    input logic [SYM_BITS-1:0] b);
        logic [SYM_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_LEN_W) s = s - ALPHA_LEN_W;
        return s[SYM_BITS-1:0];
    endfunction

    function automatic logic [SYM_BITS-1:0] mod_sub(input logic [SYM_BITS-1:0] a,
                                                    input logic [SYM_BITS-1:0] b);
        logic [SYM_BITS:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + ALPHA_LEN_W - {1'b0, b};
        return s[SYM_BITS-1:0];
    endfunction

    // Notch of rotor i: wheel III (V), II (E), I (Q) repeating from rotor 0.
    function automatic logic [SYM_BITS-1:0] notch_of(input int unsigned i);
        case (i % 3)
            0:       return SYM_BITS'(21);
            1:       return SYM_BITS'(4);
            default: return SYM_BITS'(16);
        endcase
    endfunction

endpackage

// File: rtl/rotor_stage.sv
// One combinational cipher stage: forward/reverse rotor pass or reflector.
// Wheel select 0/1/2 = III/II/I.
module rotor_stage
    import enigma_pkg::*;
(
    input  logic [SYM_BITS-1:0] i_c,
    input  logic [SYM_BITS-1:0] i_p,
    input  logic [1:0]          i_wheel,
    input  logic [1:0]          i_dir,
    output logic [SYM_BITS-1:0] o_c
);

    logic [SYM_BITS-1:0] w_c;
    logic [SYM_BITS-1:0] w_p;
    logic [SYM_BITS-1:0] w_idx;
    logic [SYM_BITS-1:0] w_wired;
    logic                w_rev;

    // Apply rotor offset, wiring lookup and offset removal (or reflect)
    always_comb begin
        w_c   = (i_c > ALPHA_MAX) ? '0 : i_c;
        w_p   = (i_p > ALPHA_MAX) ? '0 : i_p;
        w_idx = mod_add(w_c, w_p);
        w_rev = (i_dir == DIR_REV);
        case (i_wheel)
            2'd0:    w_wired = w_rev ? tbl(WIRE_III_INV, w_idx) : tbl(WIRE_III, w_idx);
            2'd1:    w_wired = w_rev ? tbl(WIRE_II_INV, w_idx)  : tbl(WIRE_II, w_idx);
            default: w_wired = w_rev ? tbl(WIRE_I_INV, w_idx)   : tbl(WIRE_I, w_idx);
        endcase
        if (i_dir == DIR_REFL) o_c = tbl(REFL_B, w_c);
        else                   o_c = mod_sub(w_wired, w_p);
    end

endmodule

// File: rtl/enigma_stream_core.sv
// Clocked Enigma engine: steps rotors on accept, then walks the symbol through
// N rotors, the reflector and back using one time-shared rotor_stage.
module enigma_stream_core
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int SYM_W      = 5,
    parameter int ALPHABET   = 26
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_load,
    input  logic [NUM_ROTORS*SYM_W-1:0] cfg_positions,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYM_W-1:0]            data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SYM_W-1:0]            data_out,
    output logic [NUM_ROTORS*SYM_W-1:0] positions,
    output logic                        busy
);

    localparam int CNT_W = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam int POS_W = NUM_ROTORS * SYM_W;
    localparam logic [SYM_W-1:0] SYM_TOP  = SYM_W'(ALPHABET - 1);
    localparam logic [CNT_W-1:0] LAST_ROT = CNT_W'(NUM_ROTORS - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_stage, w_stage_nxt;
    logic [POS_W-1:0]    r_positions, w_pos_stepped, w_pos_cfg;
    logic [SYM_W-1:0]    r_sym, r_data_out, w_cur_pos, w_stage_out;
    logic                r_illegal, r_out_valid, w_in_illegal;
    logic [NUM_ROTORS-1:0] w_step;
    logic [1:0]          w_wheel;
    stage_dir_t          w_dir;
    logic [SYM_BITS-1:0] w_rs_out;

    assign in_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign out_valid    = r_out_valid;
    assign data_out     = r_data_out;
    assign positions    = r_positions;
    assign w_in_illegal = (data_in > SYM_TOP);

    // Step decision from pre-step positions, including the double-step
    always_comb begin
        w_step    = '0;
        w_step[0] = 1'b1;
        for (int unsigned i = 1; i < NUM_ROTORS; i++) begin
            if (r_positions[SYM_W*(i-1) +: SYM_W] == SYM_W'(notch_of(i-1)))
                w_step[i] = 1'b1;
            if ((i + 2 <= NUM_ROTORS) && (r_positions[SYM_W*i +: SYM_W] == SYM_W'(notch_of(i))))
                w_step[i] = 1'b1;
        end
    end

    // Stepped positions and sanitised configuration values
    always_comb begin
        w_pos_stepped = r_positions;
        w_pos_cfg     = '0;
        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
            if (w_step[i])
                w_pos_stepped[SYM_W*i +: SYM_W] =
                    (r_positions[SYM_W*i +: SYM_W] == SYM_TOP) ? '0 : r_positions[SYM_W*i +: SYM_W] + 1'b1;
            if (cfg_positions[SYM_W*i +: SYM_W] <= SYM_TOP)
                w_pos_cfg[SYM_W*i +: SYM_W] = cfg_positions[SYM_W*i +: SYM_W];
        end
    end

    // Stage operand selection for the shared rotor_stage
    always_comb begin
        w_cur_pos = r_positions[SYM_W*r_stage +: SYM_W];
        w_wheel   = 2'(r_stage % 3);
        case (r_state)
            ST_REV:  w_dir = DIR_REV;
            ST_REFL: w_dir = DIR_REFL;
            default: w_dir = DIR_FWD;
        endcase
    end

    rotor_stage u_stage (
        .i_c     (SYM_BITS'(r_sym)),
        .i_p     (SYM_BITS'(w_cur_pos)),
        .i_wheel (w_wheel),
        .i_dir   (w_dir),
        .o_c     (w_rs_out)
    );

    assign w_stage_out = SYM_W'(w_rs_out);

    // FSM state and stage counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    // Next state: cfg_load aborts from anywhere
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        if (cfg_load) begin
            w_state_nxt = ST_IDLE;
            w_stage_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    w_state_nxt = ST_FWD;
                    w_stage_nxt = '0;
                end
                ST_FWD: begin
                    if (r_stage == LAST_ROT) w_state_nxt = ST_REFL;
                    else                     w_stage_nxt = r_stage + 1'b1;
                end
                ST_REFL: begin
                    w_state_nxt = ST_REV;
                    w_stage_nxt = LAST_ROT;
                end
                ST_REV: begin
                    if (r_stage == '0) w_state_nxt = ST_OUT;
                    else               w_stage_nxt = r_stage - 1'b1;
                end
                ST_OUT: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Positions, symbol pipeline and output register; the first OUT cycle
    // loads the output register, so out_valid rises one cycle after REV ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_positions <= '0;
            r_sym       <= '0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (cfg_load) begin
            r_positions <= w_pos_cfg;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_sym     <= data_in;
                    r_illegal <= w_in_illegal;
                    if (!w_in_illegal) r_positions <= w_pos_stepped;
                end
                ST_FWD, ST_REFL, ST_REV: if (!r_illegal) r_sym <= w_stage_out;
                ST_OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_data_out  <= r_sym;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
